// File: rtl/dm_resp_pkg.sv
// Shared types and default constants for the data-memory responder.
package dm_resp_pkg;

    localparam int unsigned DEPTH_WORDS_DEF = 256;
    localparam int unsigned WAIT_CYCLES_DEF = 2;
    localparam int unsigned CNT_W           = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

endpackage

// File: rtl/dm_array.sv
// Word-organised storage with per-byte write enables, combinational read
// and an asynchronous clear of every word.
module dm_array
    import dm_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Storage update: clear all words on reset, otherwise write enabled byte lanes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_r[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/dm_resp.sv
// Single-outstanding data-memory responder: accepts one request, waits a fixed
// number of cycles, performs the access and holds the response until consumed.
module dm_resp
    import dm_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES == 32'd0) ? 4'd0 : 4'(WAIT_CYCLES - 32'd1);

    dm_state_e        state_r;
    dm_state_e        state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic             lat_write_r;
    logic [31:0]      lat_addr_r;
    logic [31:0]      lat_wdata_r;
    logic [3:0]       lat_be_r;

    logic             req_ready_r;
    logic             rsp_valid_r;
    logic [31:0]      rsp_rdata_r;
    logic             rsp_err_r;

    logic             accept_s;
    logic             do_access_s;
    logic             acc_write_s;
    logic [31:0]      acc_addr_s;
    logic [31:0]      acc_wdata_s;
    logic [3:0]       acc_be_s;
    logic             acc_err_s;
    logic             arr_we_s;
    logic [31:0]      arr_rdata_s;

    // req_ready_r is only ever high in IDLE and out of reset.
    assign accept_s = (state_r == IDLE) & req_ready_r & req_valid;

    // Access operands: live inputs when accessing on the accept edge, latched copy otherwise.
    always_comb begin
        if (state_r == IDLE) begin
            acc_write_s = req_write;
            acc_addr_s  = req_addr;
            acc_wdata_s = req_wdata;
            acc_be_s    = req_be;
        end else begin
            acc_write_s = lat_write_r;
            acc_addr_s  = lat_addr_r;
            acc_wdata_s = lat_wdata_r;
            acc_be_s    = lat_be_r;
        end
    end

    assign acc_err_s = (acc_addr_s[1:0] != 2'b00) ||
                       (acc_addr_s[31:2] >= 30'(DEPTH_WORDS));
    assign arr_we_s  = do_access_s & acc_write_s & ~acc_err_s;

    // Next-state, wait counter and access strobe.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        do_access_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (WAIT_CYCLES == 32'd0) begin
                        do_access_s = 1'b1;
                        state_nxt_s = RESP;
                    end else begin
                        cnt_nxt_s   = CNT_LOAD;
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    do_access_s = 1'b1;
                    state_nxt_s = RESP;
                end else begin
                    cnt_nxt_s   = cnt_r - 4'd1;
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // State, counter and registered handshake/response outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            req_ready_r <= (state_nxt_s == IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
            if (do_access_s) begin
                rsp_err_r   <= acc_err_s;
                rsp_rdata_r <= (acc_err_s || acc_write_s) ? 32'h0000_0000 : arr_rdata_s;
            end
        end
    end

    // Request latch, captured only on the accept edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lat_write_r <= 1'b0;
            lat_addr_r  <= 32'h0000_0000;
            lat_wdata_r <= 32'h0000_0000;
            lat_be_r    <= 4'h0;
        end else if (accept_s) begin
            lat_write_r <= req_write;
            lat_addr_r  <= req_addr;
            lat_wdata_r <= req_wdata;
            lat_be_r    <= req_be;
        end
    end

    dm_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clock (clock),
        .reset (reset),
        .we    (arr_we_s),
        .addr  (acc_addr_s[AW+1:2]),
        .wdata (acc_wdata_s),
        .be    (acc_be_s),
        .rdata (arr_rdata_s)
    );

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule
